// File: rtl/sw_mode_ctrl.sv
// sw_mode_ctrl: switch-driven mode / freeze controller for the OV7620 board.
// sw1 advances the mode and requests a sensor reconfiguration over a
// cfg_req/cfg_ack handshake with an ack timeout; sw2 toggles a freeze flag
// that only takes effect on a vsync rising edge.
// Optional build macro: SW_DEBOUNCE_EN adds a DEB_CYCLES stability debouncer
// on the synchronized sw1/sw2 levels (vsync is never debounced).
module sw_mode_ctrl #(
  parameter int unsigned NUM_MODES   = 4,
  parameter logic [23:0] ACK_TIMEOUT = 24'd4_000_000,
  parameter logic [19:0] DEB_CYCLES  = 20'd800_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       vsync,
  input  logic       cfg_ack,
  output logic [1:0] mode,
  output logic       freeze,
  output logic       cfg_req,
  output logic [1:0] cfg_mode,
  output logic       cfg_err
);

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_t;

  localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);

  if (NUM_MODES < 2 || NUM_MODES > 4 || DEB_CYCLES == 20'd0) begin : g_param_check
    $error("sw_mode_ctrl: NUM_MODES must be 2..4 and DEB_CYCLES nonzero");
  end

  // bit 0 = sw1, bit 1 = sw2, bit 2 = vsync
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [2:0] prev_q, prev_d;
  logic [2:0] lvl;
  logic [2:0] ev;

  // Two-stage synchronizer input and edge-detector history
  always_comb begin
    meta_d = {vsync, sw2, sw1};
    sync_d = meta_q;
    prev_d = lvl;
    ev     = lvl & ~prev_q;
  end

  // Synchronizer and edge-detector registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [1:0] deb_lvl;

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic        deb_q, deb_d;
    logic [19:0] cnt_q, cnt_d;

    // Level follows the input only after DEB_CYCLES consecutive differing cycles
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync_q[g] != deb_q) begin
        if (cnt_q == DEB_CYCLES - 20'd1) begin
          deb_d = sync_q[g];
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    end

    // Debouncer state
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb_lvl[g] = deb_q;
  end

  assign lvl = {sync_q[2], deb_lvl};
`else
  assign lvl = sync_q;
`endif

  logic ev1, ev2, evv;
  assign ev1 = ev[0];
  assign ev2 = ev[1];
  assign evv = ev[2];

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d, mode_nxt;
  logic        freeze_q, freeze_d;
  logic        freeze_pend_q, freeze_pend_d;
  logic        cfg_req_q, cfg_req_d;
  logic [1:0]  cfg_mode_q, cfg_mode_d;
  logic        cfg_err_q, cfg_err_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic [23:0] tmo_q, tmo_d;

  // Mode advance, frame-aligned freeze, and request handshake next-state
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cfg_req_d  = cfg_req_q;
    cfg_mode_d = cfg_mode_q;
    cfg_err_d  = cfg_err_q;
    cfg_pend_d = cfg_pend_q;
    tmo_d      = tmo_q;

    mode_nxt = (mode_q == MODE_LAST) ? '0 : mode_q + 2'd1;
    if (ev1) begin
      mode_d = mode_nxt;
    end

    // vsync consumes the pending toggle seen before this cycle's sw2 event
    freeze_d      = freeze_q ^ (evv & freeze_pend_q);
    freeze_pend_d = (freeze_pend_q & ~evv) ^ ev2;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (ev1) begin
          state_d    = ST_REQ;
          cfg_req_d  = 1'b1;
          cfg_mode_d = mode_nxt;
          cfg_pend_d = 1'b0;
        end else if (cfg_pend_q) begin
          state_d    = ST_REQ;
          cfg_req_d  = 1'b1;
          cfg_mode_d = mode_q;
          cfg_pend_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (ev1) begin
          cfg_pend_d = 1'b1;
        end
        if (cfg_ack) begin
          state_d   = ST_IDLE;
          cfg_req_d = 1'b0;
          tmo_d     = '0;
        end else if (tmo_q == ACK_TIMEOUT - 24'd1) begin
          state_d   = ST_IDLE;
          cfg_req_d = 1'b0;
          cfg_err_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cfg_req_d = 1'b0;
        tmo_d     = '0;
      end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= '0;
      freeze_q      <= 1'b0;
      freeze_pend_q <= 1'b0;
      cfg_req_q     <= 1'b0;
      cfg_mode_q    <= '0;
      cfg_err_q     <= 1'b0;
      cfg_pend_q    <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      freeze_q      <= freeze_d;
      freeze_pend_q <= freeze_pend_d;
      cfg_req_q     <= cfg_req_d;
      cfg_mode_q    <= cfg_mode_d;
      cfg_err_q     <= cfg_err_d;
      cfg_pend_q    <= cfg_pend_d;
      tmo_q         <= tmo_d;
    end
  end

  assign mode     = mode_q;
  assign freeze   = freeze_q;
  assign cfg_req  = cfg_req_q;
  assign cfg_mode = cfg_mode_q;
  assign cfg_err  = cfg_err_q;

endmodule
